// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory bridge.
//   dmem_state_t : bridge FSM states
//   SZ_B/SZ_H/SZ_W : access size codes carried on data_sz (3 also means word)
//   lane_offset() : byte lane where an access of a given size starts
//   be_gen()      : byte enables for an access of a given size/offset
// -----------------------------------------------------------------------------
package dmem_pkg;

   // ST_WAIT: a posted write is still draining on the bus while the MEM-stage
   // access sits in the pending slot behind it (write-buffer builds only).
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } dmem_state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Half accesses ignore addr[0], word accesses ignore addr[1:0].
   function automatic logic [1:0] lane_offset(input logic [1:0] sz,
                                              input logic [1:0] addr_lo);
      logic [1:0] off;
      case (sz)
         SZ_B:    off = addr_lo;
         SZ_H:    off = {addr_lo[1], 1'b0};
         default: off = 2'b00;
      endcase
      return off;
   endfunction

   function automatic logic [3:0] be_gen(input logic [1:0] sz,
                                         input logic [1:0] addr_lo);
      logic [3:0] be;
      logic [1:0] off;
      off = lane_offset(sz, addr_lo);
      case (sz)
         SZ_B:    be = 4'b0001 << off;
         SZ_H:    be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// External word-wide memory bus (req/ack, variable latency).
//   ext_req   : transaction valid, held with stable fields until ext_ack
//   ext_we    : 1 write, 0 read
//   ext_addr  : word address (AW-2 bits)
//   ext_be    : byte enables
//   ext_wdata : lane-aligned write data
//   ext_rdata : read word, valid with ext_ack
//   ext_ack   : transaction completes at this rising edge
// Modports: master (bridge side), slave (memory fabric side).
// -----------------------------------------------------------------------------
interface dmem_if #(
   parameter int AW = 32
);
   logic          ext_req;
   logic          ext_we;
   logic [AW-3:0] ext_addr;
   logic [3:0]    ext_be;
   logic [31:0]   ext_wdata;
   logic [31:0]   ext_rdata;
   logic          ext_ack;

   modport master (
      output ext_req, ext_we, ext_addr, ext_be, ext_wdata,
      input  ext_rdata, ext_ack
   );

   modport slave (
      input  ext_req, ext_we, ext_addr, ext_be, ext_wdata,
      output ext_rdata, ext_ack
   );
endinterface

// File: rtl/dmem_lane.sv
// -----------------------------------------------------------------------------
// dmem_lane
// Pure combinational byte-lane steering shared by the request and response
// paths of the bridge.
//   req_sz, req_addr_lo, req_wdata : incoming access (size, low address, data)
//   req_be, req_lane_wdata         : byte enables and lane-replicated data
//   rsp_sz, rsp_addr_lo, rsp_word  : in-flight read access and returned word
//   rsp_data                       : right-justified, zero-masked load data
// -----------------------------------------------------------------------------
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [1:0]  req_sz,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_wdata,
   output logic [3:0]  req_be,
   output logic [31:0] req_lane_wdata,
   input  logic [1:0]  rsp_sz,
   input  logic [1:0]  rsp_addr_lo,
   input  logic [31:0] rsp_word,
   output logic [31:0] rsp_data
);

   logic [1:0]  rsp_off;
   logic [31:0] rsp_shifted;

   assign req_be = be_gen(req_sz, req_addr_lo);

   // Store data is replicated into every lane of its size so the byte
   // enables alone select where it lands.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         always_comb begin
            case (req_sz)
               SZ_B:    req_lane_wdata[8*gi +: 8] = req_wdata[7:0];
               SZ_H:    req_lane_wdata[8*gi +: 8] = req_wdata[8*(gi%2) +: 8];
               default: req_lane_wdata[8*gi +: 8] = req_wdata[8*gi +: 8];
            endcase
         end
      end
   endgenerate

   assign rsp_off     = lane_offset(rsp_sz, rsp_addr_lo);
   assign rsp_shifted = rsp_word >> {rsp_off, 3'b000};

   always_comb begin
      case (rsp_sz)
         SZ_B:    rsp_data = {24'd0, rsp_shifted[7:0]};
         SZ_H:    rsp_data = {16'd0, rsp_shifted[15:0]};
         default: rsp_data = rsp_shifted;
      endcase
   end

endmodule

// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
// Data-memory responder for the core's data port. Each byte/half/word load or
// store accepted in EX becomes one byte-enabled word transaction on the
// external bus; data_busy stalls the core in MEM until the access completes.
//   clk, rst_n        : clock, asynchronous active-low reset
//   data_r / data_w   : load / store request (EX cycle)
//   data_sz           : 0 byte, 1 half, 2/3 word
//   data_addr         : byte address
//   data_wdata        : store data, right-justified
//   data_rdata        : load data, right-justified, zero-extended
//   data_busy         : MEM-cycle access not yet complete
//   ext               : external memory bus (dmem_if.master)
// Build option: DMEM_WBUF_EN enables a single-entry posted write buffer.
// -----------------------------------------------------------------------------
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          data_r,
   input  logic          data_w,
   input  logic [1:0]    data_sz,
   input  logic [AW-1:0] data_addr,
   input  logic [31:0]   data_wdata,
   output logic [31:0]   data_rdata,
   output logic          data_busy,
   dmem_if.master        ext
);

`ifdef DMEM_WBUF_EN
   localparam bit WBUF_EN = 1'b1;
`else
   localparam bit WBUF_EN = 1'b0;
`endif

   dmem_state_t state_reg, state_next;

   // Transaction currently on the bus.
   logic          cur_we_reg;
   logic [AW-3:0] cur_addr_reg;
   logic [3:0]    cur_be_reg;
   logic [31:0]   cur_wdata_reg;
   logic [1:0]    cur_sz_reg;
   logic [1:0]    cur_off_reg;
   logic          cur_posted_reg;   // posted write: the core is not waiting on it

   // MEM-stage access parked behind a draining posted write.
   logic          pend_we_reg;
   logic [AW-3:0] pend_addr_reg;
   logic [3:0]    pend_be_reg;
   logic [31:0]   pend_wdata_reg;
   logic [1:0]    pend_sz_reg;
   logic [1:0]    pend_off_reg;

   logic          ack;
   logic          busy;
   logic          accept;
   logic          load_new;
   logic          load_from_pend;
   logic          load_pend;
   logic [3:0]    req_be;
   logic [31:0]   req_lane_wdata;
   logic [31:0]   rsp_data;

   dmem_lane u_lane (
      .req_sz         (data_sz),
      .req_addr_lo    (data_addr[1:0]),
      .req_wdata      (data_wdata),
      .req_be         (req_be),
      .req_lane_wdata (req_lane_wdata),
      .rsp_sz         (cur_sz_reg),
      .rsp_addr_lo    (cur_off_reg),
      .rsp_word       (ext.ext_rdata),
      .rsp_data       (rsp_data)
   );

   // An ack with no transaction outstanding is meaningless and ignored.
   assign ack = ext.ext_ack && (state_reg != ST_IDLE);

   // In ST_WAIT a pending store is released by the drain ack (it becomes the
   // new buffered write); a pending load must still go out and complete.
   always_comb begin
      busy = 1'b0;
      case (state_reg)
         ST_REQ:  busy = !cur_posted_reg && !ext.ext_ack;
         ST_WAIT: busy = !pend_we_reg || !ext.ext_ack;
         default: busy = 1'b0;
      endcase
   end

   assign accept = (data_r || data_w) && !busy;

   always_comb begin
      state_next     = state_reg;
      load_new       = 1'b0;
      load_from_pend = 1'b0;
      load_pend      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               load_new   = 1'b1;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ack) begin
               if (accept) begin
                  load_new   = 1'b1;
                  state_next = ST_REQ;
               end else begin
                  state_next = ST_IDLE;
               end
            end else if (accept) begin
               // Only reachable while a posted write is still draining.
               load_pend  = 1'b1;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ack) begin
               load_from_pend = 1'b1;
               if (accept) begin
                  load_pend  = 1'b1;
                  state_next = ST_WAIT;
               end else begin
                  state_next = ST_REQ;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_we_reg     <= 1'b0;
         cur_addr_reg   <= '0;
         cur_be_reg     <= 4'd0;
         cur_wdata_reg  <= 32'd0;
         cur_sz_reg     <= 2'd0;
         cur_off_reg    <= 2'd0;
         cur_posted_reg <= 1'b0;
         pend_we_reg    <= 1'b0;
         pend_addr_reg  <= '0;
         pend_be_reg    <= 4'd0;
         pend_wdata_reg <= 32'd0;
         pend_sz_reg    <= 2'd0;
         pend_off_reg   <= 2'd0;
      end else begin
         if (load_new) begin
            cur_we_reg     <= data_w;
            cur_addr_reg   <= data_addr[AW-1:2];
            cur_be_reg     <= req_be;
            cur_wdata_reg  <= req_lane_wdata;
            cur_sz_reg     <= data_sz;
            cur_off_reg    <= data_addr[1:0];
            cur_posted_reg <= WBUF_EN && data_w;
         end else if (load_from_pend) begin
            cur_we_reg     <= pend_we_reg;
            cur_addr_reg   <= pend_addr_reg;
            cur_be_reg     <= pend_be_reg;
            cur_wdata_reg  <= pend_wdata_reg;
            cur_sz_reg     <= pend_sz_reg;
            cur_off_reg    <= pend_off_reg;
            cur_posted_reg <= WBUF_EN && pend_we_reg;
         end
         if (load_pend) begin
            pend_we_reg    <= data_w;
            pend_addr_reg  <= data_addr[AW-1:2];
            pend_be_reg    <= req_be;
            pend_wdata_reg <= req_lane_wdata;
            pend_sz_reg    <= data_sz;
            pend_off_reg   <= data_addr[1:0];
         end
      end
   end

   assign ext.ext_req   = (state_reg != ST_IDLE);
   assign ext.ext_we    = cur_we_reg;
   assign ext.ext_addr  = cur_addr_reg;
   assign ext.ext_be    = cur_be_reg;
   assign ext.ext_wdata = cur_wdata_reg;

   assign data_busy  = busy;
   assign data_rdata = (ack && !cur_we_reg) ? rsp_data : 32'd0;

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          data_r, data_w;
   logic [1:0]    data_sz;
   logic [AW-1:0] data_addr;
   logic [31:0]   data_wdata;
   logic [31:0]   data_rdata;
   logic          data_busy;

   always #5 clk = ~clk;

   dmem_if #(.AW(AW)) ext ();

   dmem_bridge #(.AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_r     (data_r),
      .data_w     (data_w),
      .data_sz    (data_sz),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_rdata (data_rdata),
      .data_busy  (data_busy),
      .ext        (ext)
   );

   int checks = 0;
   int errors = 0;

   // Expected external transaction, derived from the access rules.
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          off;
      int          n;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic        r;
      logic        w;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rword;
      logic [3:0]  be;
      logic [31:0] eaddr;
      logic [31:0] ewdata;
      logic [31:0] erdata;
   } vec_t;
   vec_t vec [10];

   // Snapshot of the last sampled cycle.
   logic        s_busy, s_req, s_we, s_ack, s_acc;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_be;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic exp_t model_req(input logic we, input logic [1:0] sz,
                                      input logic [31:0] addr, input logic [31:0] wd);
      exp_t e;
      int   n;
      n      = nbytes(sz);
      e.n    = n;
      e.off  = (int'(addr % 4) / n) * n;
      e.we   = we;
      e.addr = addr / 4;
      e.be   = 4'(((1 << n) - 1) << e.off);
      for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = wd[8*(k % n) +: 8];
      return e;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input int n);
      logic [63:0] v;
      v = {32'd0, w} >> (8 * off);
      if (n < 4) v = v & ((64'd1 << (8 * n)) - 64'd1);
      return v[31:0];
   endfunction

   task automatic model_cycle();
      logic acc, ackv;
      exp_t e;
      acc  = (data_r || data_w) && !data_busy;
      ackv = ext.ext_req && ext.ext_ack;
`ifndef DMEM_WBUF_EN
      chk("model_busy", 32'(data_busy), 32'(exp_q.size() != 0 && !ext.ext_ack));
      chk("model_req", 32'(ext.ext_req), 32'(exp_q.size() != 0));
`endif
      if (ackv) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_txn: got ack with nothing expected");
         end else begin
            e = exp_q.pop_front();
            chk("txn_we", 32'(ext.ext_we), 32'(e.we));
            chk("txn_addr", 32'(ext.ext_addr), e.addr);
            chk("txn_be", 32'(ext.ext_be), 32'(e.be));
            if (e.we) chk("txn_wdata", ext.ext_wdata, e.wdata);
            else      chk("txn_rdata", data_rdata, model_load(ext.ext_rdata, e.off, e.n));
            $display("txn we=%0d addr=%h be=%h wdata=%h rdata=%h",
                     ext.ext_we, ext.ext_addr, ext.ext_be, ext.ext_wdata, data_rdata);
         end
      end else begin
         chk("rdata_idle", data_rdata, 32'd0);
      end
      if (acc) exp_q.push_back(model_req(data_w, data_sz, data_addr, data_wdata));
   endtask

   task automatic tick();
      @(negedge clk);
      s_busy  = data_busy;
      s_req   = ext.ext_req;
      s_we    = ext.ext_we;
      s_addr  = 32'(ext.ext_addr);
      s_be    = ext.ext_be;
      s_wdata = ext.ext_wdata;
      s_rdata = data_rdata;
      s_ack   = ext.ext_req && ext.ext_ack;
      s_acc   = (data_r || data_w) && !data_busy;
      if (rst_n) model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic ack, input logic [31:0] rword);
      data_r        = r;
      data_w        = w;
      data_sz       = sz;
      data_addr     = addr;
      data_wdata    = wd;
      ext.ext_ack   = ack;
      ext.ext_rdata = rword;
   endtask

   initial begin
      int stall, nb, nack;
      logic [31:0] rd;

      vec[0] = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'h1122_3344, 4'hF, 32'h40,       32'h0,        32'h1122_3344};
      vec[1] = '{1'b1, 1'b0, 2'd0, 32'h0000_0103, 32'h0, 32'hAABB_CCDD, 4'h8, 32'h40,       32'h0,        32'h0000_00AA};
      vec[2] = '{1'b1, 1'b0, 2'd0, 32'h0000_0101, 32'h0, 32'hAABB_CCDD, 4'h2, 32'h40,       32'h0,        32'h0000_00CC};
      vec[3] = '{1'b1, 1'b0, 2'd1, 32'h0000_0102, 32'h0, 32'hAABB_CCDD, 4'hC, 32'h40,       32'h0,        32'h0000_AABB};
      vec[4] = '{1'b1, 1'b0, 2'd1, 32'h0000_0101, 32'h0, 32'hAABB_CCDD, 4'h3, 32'h40,       32'h0,        32'h0000_CCDD};
      vec[5] = '{1'b0, 1'b1, 2'd1, 32'h0000_0206, 32'hDEAD_1234, 32'h0, 4'hC, 32'h81,       32'h1234_1234, 32'h0};
      vec[6] = '{1'b0, 1'b1, 2'd0, 32'h0000_0205, 32'hFFFF_FF5A, 32'h0, 4'h2, 32'h81,       32'h5A5A_5A5A, 32'h0};
      vec[7] = '{1'b0, 1'b1, 2'd3, 32'h0000_020B, 32'hCAFE_BABE, 32'h0, 4'hF, 32'h82,       32'hCAFE_BABE, 32'h0};
      vec[8] = '{1'b1, 1'b0, 2'd3, 32'h0000_0003, 32'h0, 32'h8765_4321, 4'hF, 32'h0,        32'h0,        32'h8765_4321};
      vec[9] = '{1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0077, 32'h0, 4'h8, 32'h3FFF_FFFF, 32'h7777_7777, 32'h0};

      drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
      #1 rst_n = 1'b0;
      #1;
      chk("reset_req", 32'(ext.ext_req), 32'h0);
      chk("reset_we", 32'(ext.ext_we), 32'h0);
      chk("reset_addr", 32'(ext.ext_addr), 32'h0);
      chk("reset_be", 32'(ext.ext_be), 32'h0);
      chk("reset_wdata", ext.ext_wdata, 32'h0);
      chk("reset_busy", 32'(data_busy), 32'h0);
      chk("reset_rdata", data_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Lane mapping, ack in the first REQ cycle (zero stall).
      for (int i = 0; i < 10; i++) begin
         drive(vec[i].r, vec[i].w, vec[i].sz, vec[i].addr, vec[i].wdata, 1'b0, 32'h0);
         tick();
         chk("vec_accept", 32'(s_acc), 32'h1);
         drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, vec[i].rword);
         tick();
         chk("vec_req", 32'(s_req), 32'h1);
         chk("vec_zero_stall", 32'(s_busy), 32'h0);
         chk("vec_we", 32'(s_we), 32'(vec[i].w));
         chk("vec_addr", s_addr, vec[i].eaddr);
         chk("vec_be", 32'(s_be), 32'(vec[i].be));
         if (vec[i].w) chk("vec_wdata", s_wdata, vec[i].ewdata);
         else          chk("vec_rdata", s_rdata, vec[i].erdata);
         drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
         tick();
      end

      // Byte load with late ack: three stall cycles.
      drive(1'b1, 1'b0, 2'd0, 32'h103, 32'h0, 1'b0, 32'h0);
      tick();
      stall = 0;
      rd = 32'h0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, i == 3, 32'hAABB_CCDD);
         tick();
         if (s_busy) stall++;
         if (s_ack) rd = s_rdata;
      end
      chk("late_stall", 32'(stall), 32'd3);
      chk("late_rdata", rd, 32'h0000_00AA);

      // Load then store back-to-back, ack in the second request's EX cycle.
      drive(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b1, 2'd2, 32'h300, 32'h55, 1'b1, 32'h1234_5678);
      tick();
      chk("b2b_ack", 32'(s_ack), 32'h1);
      chk("b2b_accept", 32'(s_acc), 32'h1);
      chk("b2b_rdata", s_rdata, 32'h1234_5678);
      drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      chk("b2b_req", 32'(s_req), 32'h1);
      chk("b2b_we", 32'(s_we), 32'h1);
      chk("b2b_addr", s_addr, 32'hC0);
      chk("b2b_wdata", s_wdata, 32'h55);
      drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h0);
      tick();
      chk("b2b_done", 32'(s_ack), 32'h1);
      drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      chk("b2b_idle", 32'(s_req), 32'h0);

      // Reset in the middle of a read transaction; the late ack is ignored.
      drive(1'b1, 1'b0, 2'd2, 32'h44, 32'h0, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
      #2;
      chk("rst_pre_req", 32'(ext.ext_req), 32'h1);
      chk("rst_pre_addr", 32'(ext.ext_addr), 32'h11);
      rst_n = 1'b0;
      ext.ext_ack = 1'b1;
      ext.ext_rdata = 32'hFFFF_FFFF;
      #1;
      chk("rst_mid_req", 32'(ext.ext_req), 32'h0);
      chk("rst_mid_addr", 32'(ext.ext_addr), 32'h0);
      chk("rst_mid_be", 32'(ext.ext_be), 32'h0);
      chk("rst_mid_we", 32'(ext.ext_we), 32'h0);
      chk("rst_mid_wdata", ext.ext_wdata, 32'h0);
      chk("rst_mid_busy", 32'(data_busy), 32'h0);
      chk("rst_mid_rdata", data_rdata, 32'h0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_after_req", 32'(s_req), 32'h0);
      chk("rst_after_busy", 32'(s_busy), 32'h0);
      chk("rst_after_rdata", s_rdata, 32'h0);
      drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();

`ifdef DMEM_WBUF_EN
      // Posted store followed by a load that must wait for the drain.
      drive(1'b0, 1'b1, 2'd2, 32'h400, 32'h1111, 1'b0, 32'h0);
      tick();
      drive(1'b1, 1'b0, 2'd2, 32'h500, 32'h0, 1'b0, 32'h0);
      tick();
      chk("wb_store_busy", 32'(s_busy), 32'h0);
      chk("wb_load_accept", 32'(s_acc), 32'h1);
      nb = 0;
      nack = 0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, (i == 3) || (i == 8), 32'h9999_AAAA);
         tick();
         if (s_busy) nb++;
         if (s_ack) begin
            nack++;
            if (nack == 1) begin
               chk("wb_first_we", 32'(s_we), 32'h1);
               chk("wb_first_addr", s_addr, 32'h100);
            end else begin
               chk("wb_second_we", 32'(s_we), 32'h0);
               chk("wb_second_addr", s_addr, 32'h140);
               chk("wb_second_rdata", s_rdata, 32'h9999_AAAA);
            end
         end
      end
      chk("wb_load_busy_cycles", 32'(nb), 32'd8);
      chk("wb_ack_count", 32'(nack), 32'd2);
`endif

      // Randomized traffic checked by the transaction model.
      for (int c = 0; c < 1500; c++) begin
         int rq;
         rq = int'($urandom % 4);
         drive(rq == 0, rq == 1, 2'($urandom % 4), $urandom, $urandom,
               ($urandom % 3) == 0, $urandom);
         tick();
      end

      // Drain whatever is still outstanding, with a bounded budget.
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, $urandom);
         tick();
      end
      chk("drain_empty", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory responder for the core's data port: accepts byte/half/word load and store requests issued from EX and completes them in MEM, raising `data_busy` to stall the pipeline until done. Converts each access into one word-wide, byte-enabled transaction on the external memory bus (req/ack, variable latency). Sits between the core's data port and the memory fabric, opposite the memory stage.

## Interface
Parameters:
- `AW`, 32, byte-address width of the core data port; external address is `AW-2` bits (word address).

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `data_r`  in  1  load request (valid in EX cycle)
- `data_w`  in  1  store request; `data_r` and `data_w` never both high
- `data_sz`  in  2  0 byte, 1 half, 2/3 word
- `data_addr`  in  AW  byte address
- `data_wdata`  in  32  store data, right-justified, unshifted
- `data_rdata`  out  32  load data, right-justified, upper bits zero (core sign-extends)
- `data_busy`  out  1  MEM-cycle access not complete; core stalls
- `ext_req`  out  1  external transaction valid
- `ext_we`  out  1  1 write, 0 read
- `ext_addr`  out  AW-2  word address
- `ext_be`  out  4  byte enables
- `ext_wdata`  out  32  lane-aligned write data
- `ext_rdata`  in  32  read word, valid when `ext_ack`
- `ext_ack`  in  1  transaction completes at this rising edge

## Operation
- Acceptance: request accepted at a rising edge when (`data_r`|`data_w`) and `data_busy` low. Requests presented while `data_busy` high are ignored (core is stalled and re-presents).
- Lane mapping: byte → lane `addr[1:0]`, be `4'b0001<<addr[1:0]`; half → lanes `{addr[1],0}`, be `4'b0011<<{addr[1],0}`, `addr[0]` ignored; word → be `4'b1111`, `addr[1:0]` ignored. Write data replicated to all lanes of its size; read data shifted down by the lane offset and zero-masked to size.
- FSM (`dmem_state_t`): IDLE → REQ on accept; REQ holds `ext_req` with stable addr/we/be/wdata until `ext_ack`; on ack → IDLE, or directly REQ again if a new request is accepted that same edge.
- `data_busy` = (state==REQ, access owned by MEM) && !`ext_ack`. `data_rdata` = lane-shifted `ext_rdata` combinationally in the ack cycle; 0 otherwise.
- External bus is the only side effect; no retries, no error response.

## Timing
- Reset: state IDLE, `ext_req`=0, `ext_we`=0, `ext_addr`=0, `ext_be`=0, `ext_wdata`=0, `data_busy`=0, `data_rdata`=0, write buffer empty.
- Request in EX cycle N → `ext_req` high from cycle N+1 (registered). `ext_ack` may assert in N+1 → zero stall; each later ack cycle adds one stall cycle.
- Back-to-back: ack in cycle K with a new request presented in K → new `ext_req` continuous in K+1, fields updated.
- Reset asserted mid-transaction: `ext_req` drops immediately (async); a pending ack is discarded.
- `ext_ack` while `ext_req` low is ignored.

## Configuration
- `DMEM_WBUF_EN` defined: single-entry posted write buffer. Store accepted with buffer empty and bus idle/draining → enters buffer, `data_busy` low in its MEM cycle; buffer drains as a REQ write. Store with buffer full → busy until drain ack. Load with buffer full → busy until drain completes, then issues (no forwarding; ordering preserved). Buffer occupancy does not block acceptance of the request itself.
- Not defined: every store holds `data_busy` until its `ext_ack`, same as loads.

## Structure
- `dmem_pkg`: `dmem_state_t` enum, size constants `SZ_B/SZ_H/SZ_W`, functions for be generation.
- Sub-module `dmem_lane`: pure combinational lane steering (be, write replication, read shift/mask), instanced once for write path and read path share.

## Test plan
- Word load 0x100, ack in first REQ cycle → `ext_be`=4'hF, `ext_addr`=0x40, zero stall, `data_rdata`=ext word.
- Byte load 0x103, `ext_rdata`=0xAABBCCDD, ack after 3 cycles → 3 stall cycles, `data_rdata`=0x000000AA.
- Half store 0x206 data 0x1234 → `ext_be`=4'b1100, `ext_wdata`=0x12341234, `ext_we`=1.
- Load then store back-to-back, ack same cycle as second request → `ext_req` stays high, fields switch next cycle, no idle gap.
- With `DMEM_WBUF_EN`: store then load, ack delayed 4 cycles → store busy=0, load busy until drain ack + read ack, ext order write then read.
- Assert `rst_n`=0 mid-REQ → `ext_req` drops same cycle, all outputs at reset values; late `ext_ack` ignored.
